// File: rtl/cla_multibyte_sequencer.sv
// Byte-serial wide add/subtract around one 8-bit CLA; result valid NBYTES cycles after accept.
// in_ready only in IDLE; the result is held in DONE until out_ready, then one IDLE cycle.
module carrylookahead_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened generate/propagate product, not a ripple chain.
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];
endmodule

module cla_multibyte_sequencer #(
    parameter int NBYTES = 4,
    localparam int W     = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [NBYTES-1:0][7:0]  s_q, s_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;

    logic [7:0] cla_sum;
    logic       cla_cout;

    carrylookahead_adder u_cla (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                s_d[idx_q] = cla_sum;
                carry_d    = cla_cout;
                idx_d      = idx_q + 1'b1;
                if (idx_q == IW'(NBYTES - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = cla_cout;
                    // b_q already holds the inverted operand when subtracting.
                    ovf_d   = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                              (cla_sum[7] != a_q[NBYTES-1][7]);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_multibyte_sequencer.sv
// Directed bench for the byte-serial CLA sequencer at NBYTES=4.
module tb_cla_multibyte_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] s;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    logic [31:0] s_hold;

    cla_multibyte_sequencer #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one bundle, optionally toggle in_valid/out_ready during RUN,
    // and return the number of edges from accept to out_valid.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                         input logic tsub, input bit noise, output int latency);
        @(negedge clk);
        check("in_ready_before_op", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a = ta; b = tb_v; cin = tcin; sub = tsub;
        @(posedge clk);
        #1;
        in_valid = noise;
        out_ready = noise;
        if (noise) begin
            a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = ~tsub;
        end
        latency = 0;
        while (!out_valid && latency < 20) begin
            @(posedge clk);
            #1;
            latency++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", {63'd0, out_valid}, 64'd0);
        check("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_s", {32'd0, s}, 64'd0);
        check("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: all-ones plus one wraps with carry-out, busy inputs toggled during RUN
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_s", {32'd0, s}, 64'h0000_0000);
        check("t1_cout_ovf", {62'd0, cout, ovf}, 64'b10);
        finish_op();

        // 2: cin ripples across the byte-0 boundary
        do_op(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, lat);
        check("t2_latency", 64'(lat), 64'd4);
        check("t2_s", {32'd0, s}, 64'h0000_0100);
        check("t2_cout_ovf", {62'd0, cout, ovf}, 64'b00);
        finish_op();

        // 3: signed overflow on add and on subtract
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, lat);
        check("t3a_s", {32'd0, s}, 64'h8000_0000);
        check("t3a_cout_ovf", {62'd0, cout, ovf}, 64'b01);
        finish_op();
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, lat);
        check("t3b_s", {32'd0, s}, 64'h7FFF_FFFF);
        check("t3b_cout_ovf", {62'd0, cout, ovf}, 64'b11);
        finish_op();

        // 4: subtract ignores cin; borrow shows as cout=0
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, lat);
        check("t4_s", {32'd0, s}, 64'hFFFF_FFFE);
        check("t4_cout_ovf", {62'd0, cout, ovf}, 64'b00);
        finish_op();

        // 5: result held under backpressure, in_valid ignored while DONE
        do_op(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 1'b0, lat);
        s_hold = s;
        check("t5_s", {32'd0, s}, 64'h9999_9999);
        in_valid = 1'b1;
        a = 32'h1111_1111; b = 32'h2222_2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_hold_valid", {63'd0, out_valid}, 64'd1);
            check("t5_hold_ready", {63'd0, in_ready}, 64'd0);
            check("t5_hold_s", {32'd0, s}, {32'd0, s_hold});
            check("t5_hold_cout_ovf", {62'd0, cout, ovf}, 64'b00);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("t5_out_valid_drop", {63'd0, out_valid}, 64'd0);
        do_op(32'h0000_0010, 32'h0000_0003, 1'b0, 1'b1, 1'b0, lat);
        check("t5_next_latency", 64'(lat), 64'd4);
        check("t5_next_s", {32'd0, s}, 64'h0000_000D);
        check("t5_next_cout_ovf", {62'd0, cout, ovf}, 64'b10);
        finish_op();

        // 6: reset during the third RUN cycle discards the pending result
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_s", {32'd0, s}, 64'd0);
        check("t6_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("t6_rst_cout_ovf", {62'd0, cout, ovf}, 64'b00);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, lat);
        check("t6_latency", 64'(lat), 64'd4);
        check("t6_s", {32'd0, s}, 64'h2345_6789);
        check("t6_cout_ovf", {62'd0, cout, ovf}, 64'b00);
        finish_op();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
